// File: rtl/rotate_sdram_bridge.sv
// Arbiter between the rotation core's 8-word write bursts and row-read bursts onto one SDRAM word port.
// Optional ROTATE_BRIDGE_STATS_EN builds the stat_wr_stall counter; otherwise the port is tied to zero.
module rotate_sdram_bridge #(
  parameter int                    HCNT_WIDTH = 10,
  parameter int                    ADDR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(24'h200000)
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  vidin_req,
  input  logic [1:0]            vidin_frame,
  input  logic [HCNT_WIDTH-1:0] vidin_x,
  input  logic [HCNT_WIDTH-1:0] vidin_y,
  input  logic [15:0]           vidin_d,
  output logic                  vidin_ack,
  input  logic                  vidout_req,
  input  logic [1:0]            vidout_frame,
  input  logic [HCNT_WIDTH-1:0] vidout_x,
  input  logic [HCNT_WIDTH-1:0] vidout_y,
  output logic [15:0]           vidout_d,
  output logic                  vidout_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_rdata,
  output logic [15:0]           stat_wr_stall
);

  typedef enum logic [1:0] {IDLE = 2'd0, WR_ISSUE = 2'd1, WR_GAP = 2'd2, RD_ISSUE = 2'd3} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              cnt;
  logic                    gap_q;
  logic [1:0]              rd_frame;
  logic [HCNT_WIDTH-1:0]   rd_y, rd_x0, rd_x;
  logic                    acked, issue_wr, issue_rd, latch_rd, wr_done, rd_done, rd_keep;

  function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [1:0] f,
                                                     input logic [HCNT_WIDTH-1:0] y,
                                                     input logic [HCNT_WIDTH-1:0] x);
    return BASE_ADDR + ADDR_WIDTH'({f, y, x});
  endfunction

  // mem_ack only counts against a request we actually have outstanding
  assign acked = mem_req & mem_ack;
  assign rd_x  = rd_x0 + HCNT_WIDTH'(cnt);

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (vidin_req)       state_nxt = WR_ISSUE;
                else if (vidout_req) state_nxt = RD_ISSUE;
      WR_ISSUE: if (acked)           state_nxt = WR_GAP;
      WR_GAP:   if (gap_q)           state_nxt = (cnt == 3'd0) ? IDLE : WR_ISSUE;
      RD_ISSUE: if (acked && (cnt == 3'd7 || !vidout_req)) state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue_wr = (state == WR_ISSUE) && !mem_req;
    issue_rd = (state == RD_ISSUE) && !mem_req;
    latch_rd = (state == IDLE) && !vidin_req && vidout_req;
    wr_done  = (state == WR_ISSUE) && acked;
    rd_done  = (state == RD_ISSUE) && acked;
    rd_keep  = rd_done && vidout_req;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      vidin_ack  <= 1'b0;
      vidout_ack <= 1'b0;
      vidout_d   <= '0;
      cnt        <= '0;
      gap_q      <= 1'b0;
      rd_frame   <= '0;
      rd_y       <= '0;
      rd_x0      <= '0;
    end else begin
      vidin_ack  <= wr_done;
      vidout_ack <= rd_keep;
      // two-cycle gap lets upstream advance and re-register the next word
      gap_q      <= (state == WR_GAP) ? ~gap_q : 1'b0;
      if (latch_rd) begin
        rd_frame <= vidout_frame;
        rd_y     <= vidout_y;
        rd_x0    <= vidout_x;
      end
      // write address is taken per word since a transposed burst walks y
      if (issue_wr) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= map_addr(vidin_frame, vidin_y, vidin_x);
        mem_wdata <= vidin_d;
      end else if (issue_rd) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= map_addr(rd_frame, rd_y, rd_x);
      end else if (acked) begin
        mem_req   <= 1'b0;
      end
      if (rd_keep) vidout_d <= mem_rdata;
      if (wr_done || rd_keep) cnt <= cnt + 3'd1;
      else if (rd_done)       cnt <= '0;
    end
  end

`ifdef ROTATE_BRIDGE_STATS_EN
  logic        frame0_q;
  logic [15:0] stall_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      frame0_q  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      frame0_q <= vidin_frame[0];
      if (vidin_frame[0] && !frame0_q)
        stall_cnt <= '0;
      else if (vidin_req && state == RD_ISSUE && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stat_wr_stall = stall_cnt;
`else
  assign stat_wr_stall = 16'h0;
`endif

endmodule
